jtag_host: RTL
==============

# jtag_host

Host-side JTAG driver that generates `tck`/`tms`/`tdi` and samples `tdo` to walk the MCU JTAG port's six-state machine (IDLE, I-SEL, D-SEL, I-SHFT, D-SHFT, UPDATE). It turns single-word commands into complete instruction scans (8 bits) or data scans (16 bits), and returns the bits captured from `tdo`. It is the bench and debug-bridge counterpart of the MCU's JTAG port. Everything is clocked by the system clock, and TCK is derived from it.

## Interface
- `DIV`, default 4: TCK half-period in `clk` cycles; must be ≥1.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: host idle and synced; a command is accepted on `cmd_valid & cmd_ready`.
- `cmd_op` in 2: operation; 00 SYNC, 01 ISCAN, 10 DSCAN, 11 treated as SYNC.
- `cmd_data` in 16: shift-in value; ISCAN uses [7:0], DSCAN uses [15:0].
- `rsp_valid` out 1: one-cycle pulse when a command completes.
- `rsp_data` out 16: captured TDO bits; held until the next `rsp_valid`.
- `tck` out 1: JTAG clock to the target.
- `tms` out 1: JTAG mode select.
- `tdi` out 1: JTAG data to the target.
- `tdo` in 1: JTAG data from the target.

## Operation
- **Reset values:** `tck`=0, `tms`=1, `tdi`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0.
- **Auto-sync:** after reset deassertion the host runs a SYNC automatically. No `rsp_valid` is produced. `cmd_ready` rises when the SYNC finishes.
- **TCK cycle:** each TCK cycle is a low phase of `DIV` clks followed by a high phase of `DIV` clks. `tms` and `tdi` update only on the clk that begins a low phase.
- **SYNC:** 3 rising edges with `tms`=1 and `tdi`=0. This reaches IDLE from any target state.
- **ISCAN** uses 11 edges, with `tms` per edge 0,0,0,0,0,0,0,0,0,1,0:
  - edges 1–2 walk IDLE→I-SEL→I-SHFT (the target loads status on edge 2);
  - edges 3–10 shift `cmd_data[7:0]` MSB first, with `tms`=1 on edge 10 to enter UPDATE;
  - edge 11 moves UPDATE→IDLE.
- **DSCAN** uses 20 edges, with `tms` per edge 0,1,0, then 0×15 and 1 on the shift edges, then 0:
  - edges 1–3 walk IDLE→I-SEL→D-SEL→D-SHFT;
  - edges 4–19 shift `cmd_data[15:0]` MSB first, with `tms`=1 on edge 19;
  - edge 20 moves UPDATE→IDLE.
- **`tdi` outside shift edges:** 0.
- **TDO capture:**
  - `tdo` is sampled on the clk where `tck` goes 0→1, on shift edges only.
  - Captured bits shift into a register LSB-in, so the first captured bit ends in the MSB of the scan width.
  - ISCAN result goes to `rsp_data[7:0]` with [15:8]=0. DSCAN result goes to [15:0]. SYNC result is 0.
- **Control FSM states:** RESET_SYNC, READY, LOW, HIGH, DONE.
  - READY→LOW on accept. This latches op and data and loads the edge count.
  - LOW→HIGH after `DIV` clks.
  - HIGH→LOW after `DIV` clks if edges remain, else HIGH→DONE.
  - DONE pulses `rsp_valid` for one cycle and returns to READY.
  - RESET_SYNC uses the same LOW/HIGH timing and exits to READY without a response.
- **Reset mid-operation:** all outputs return to reset values immediately and the latched command is discarded. Auto-sync follows release.
- **Overlap:** `cmd_valid` while busy is ignored and no command is queued.

## Timing
- **Accept:** `cmd_ready` drops on the clk after accept. The first low phase starts on that clk.
- **Latency:** `rsp_valid` is asserted at accept + 2·`DIV`·N + 1 clks, where N = 3 (SYNC), 11 (ISCAN) or 20 (DSCAN).
- **Next command:** `cmd_ready` reasserts on the clk after `rsp_valid`.
- **Back-to-back:** a command accepted then starts its first edge within 2·`DIV`+1 clks of the previous `rsp_valid`.
- **Auto-sync length:** after reset release, auto-sync occupies 6·`DIV` clks plus 1 before `cmd_ready`=1.
- **Counters:**
  - phase counter width is clog2(`DIV`+1), wrapping at `DIV`−1;
  - edge counter is 5 bits, counting down to 0;
  - no counter overflows for any `DIV` ≥ 1.

## Structure
- **`jtag_host_pkg`:**
  - op encodings OP_SYNC, OP_ISCAN, OP_DSCAN;
  - edge counts (3/11/20);
  - per-op TMS pattern constants (20-bit vectors, edge 1 at bit 0);
  - target command constants: NOP 0x00, SET_ADDR 0x01, READ 0x02, WRITE 0x03, SCAN 0x04, SPI 0x05, PAUSE 0x06, RUN 0x07.
- **`jtag_host_tick` sub-module:** `DIV` phase counter producing `fall_tick` and `rise_tick` strobes. The control FSM and shift registers live in the top.

## Test plan
1. **Auto-sync:** `DIV`=2, release reset.
   - Exactly 3 `tck` rising edges with `tms`=1, each TCK period 4 clks.
   - `cmd_ready`=1 at cycle 13 after release; no `rsp_valid`.
2. **ISCAN:** `cmd_data`=0x0006 against a target model reporting booted=1, paused=0.
   - `tdi` on edges 3–10 = 0,0,0,0,0,1,1,0; `tms` = 0,0,0×7,1,0.
   - `rsp_data`=0x0001.
   - Model ends in IDLE with instruction register 0x06.
3. **DSCAN:** `cmd_data`=0xA5C3 with the model's data register preloaded 0x1234.
   - `tdi` carries 0xA5C3 MSB first; `rsp_data`=0x1234.
   - Model data register = 0xA5C3; 20 edges total.
4. **Busy handling:** hold `cmd_valid` through a DSCAN.
   - No second accept while busy.
   - The next command's first falling phase starts within 2·`DIV`+1 clks of `rsp_valid`.
5. **Reset mid-DSCAN:** assert `rst` after edge 10.
   - `tck`=0 and `tms`=1 in the same cycle; no `rsp_valid`.
   - After release, auto-sync returns the model from D-SHFT to IDLE.
6. **Op 11:** `cmd_op`=11 with `cmd_data`=0xFFFF.
   - Behaves as SYNC: 3 edges, `tdi`=0 throughout, `rsp_data`=0x0000.

Source files
------------

// File: rtl/jtag_host_pkg.sv
// jtag_host_pkg: shared definitions for the host-side JTAG driver.
// Holds the command op encodings, per-op edge counts, per-op TMS and shift-edge
// patterns (20-bit vectors, edge 1 at bit 0), the target command byte values
// and the control FSM state type.
package jtag_host_pkg;

   // Command op encodings; 2'b11 is folded onto OP_SYNC by normOp().
   localparam logic [1:0] OP_SYNC  = 2'b00;
   localparam logic [1:0] OP_ISCAN = 2'b01;
   localparam logic [1:0] OP_DSCAN = 2'b10;

   // TCK rising edges per op.
   localparam logic [4:0] EDGES_SYNC  = 5'd3;
   localparam logic [4:0] EDGES_ISCAN = 5'd11;
   localparam logic [4:0] EDGES_DSCAN = 5'd20;

   // TMS value per edge.
   localparam logic [19:0] TMS_SYNC  = 20'h00007;  // edges 1-3 high
   localparam logic [19:0] TMS_ISCAN = 20'h00200;  // edge 10 high
   localparam logic [19:0] TMS_DSCAN = 20'h40002;  // edges 2 and 19 high

   // Edges that carry a data bit on TDI and capture one from TDO.
   localparam logic [19:0] SHIFT_SYNC  = 20'h00000;
   localparam logic [19:0] SHIFT_ISCAN = 20'h003FC;  // edges 3-10
   localparam logic [19:0] SHIFT_DSCAN = 20'h7FFF8;  // edges 4-19

   // Target instruction register values.
   localparam logic [7:0] CMD_NOP      = 8'h00;
   localparam logic [7:0] CMD_SET_ADDR = 8'h01;
   localparam logic [7:0] CMD_READ     = 8'h02;
   localparam logic [7:0] CMD_WRITE    = 8'h03;
   localparam logic [7:0] CMD_SCAN     = 8'h04;
   localparam logic [7:0] CMD_SPI      = 8'h05;
   localparam logic [7:0] CMD_PAUSE    = 8'h06;
   localparam logic [7:0] CMD_RUN      = 8'h07;

   typedef enum logic [2:0] {
      StResetSync,
      StReady,
      StLow,
      StHigh,
      StDone
   } hostState_t;

   function automatic logic [1:0] normOp(input logic [1:0] op);
      return (op == OP_ISCAN || op == OP_DSCAN) ? op : OP_SYNC;
   endfunction

   function automatic logic [4:0] edgeCount(input logic [1:0] op);
      case (op)
         OP_ISCAN: return EDGES_ISCAN;
         OP_DSCAN: return EDGES_DSCAN;
         default:  return EDGES_SYNC;
      endcase
   endfunction

   function automatic logic [19:0] tmsPattern(input logic [1:0] op);
      case (op)
         OP_ISCAN: return TMS_ISCAN;
         OP_DSCAN: return TMS_DSCAN;
         default:  return TMS_SYNC;
      endcase
   endfunction

   function automatic logic [19:0] shiftPattern(input logic [1:0] op);
      case (op)
         OP_ISCAN: return SHIFT_ISCAN;
         OP_DSCAN: return SHIFT_DSCAN;
         default:  return SHIFT_SYNC;
      endcase
   endfunction

endpackage

// File: rtl/jtag_host_tick.sv
// jtag_host_tick: TCK phase timer.
// While run is high, counts DIV clks per TCK phase and strobes on the last clk
// of each phase: rise_tick ends a low phase, fall_tick ends a high phase.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   run             a TCK phase is in progress (counter held at 0 otherwise)
//   tckLevel        current TCK level, selects which strobe fires
//   fall_tick       last clk of a high phase
//   rise_tick       last clk of a low phase
module jtag_host_tick #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic tckLevel,
   output logic fall_tick,
   output logic rise_tick
);

   localparam int unsigned CntW = $clog2(DIV + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);

   logic [CntW-1:0] phaseCnt;
   logic            phaseEnd;

   assign phaseEnd  = run && (phaseCnt == LastCnt);
   assign rise_tick = phaseEnd && !tckLevel;
   assign fall_tick = phaseEnd && tckLevel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phaseCnt <= '0;
      end else if (!run || phaseEnd) begin
         phaseCnt <= '0;
      end else begin
         phaseCnt <= phaseCnt + CntW'(1);
      end
   end

endmodule

// File: rtl/jtag_host.sv
// jtag_host: host-side JTAG driver.
// Turns single-word commands into complete SYNC / instruction-scan (8 bit) /
// data-scan (16 bit) sequences on tck/tms/tdi and returns the bits captured
// from tdo. Runs a SYNC automatically after reset before accepting commands.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (accept on valid & ready)
//   cmd_op              00 SYNC, 01 ISCAN, 10 DSCAN, 11 as SYNC
//   cmd_data            shift-in value (ISCAN [7:0], DSCAN [15:0])
//   rsp_valid           one-clk pulse on completion
//   rsp_data            captured TDO bits, held until the next rsp_valid
//   tck, tms, tdi       JTAG outputs to the target
//   tdo                 JTAG data from the target
module jtag_host
   import jtag_host_pkg::*;
#(
   parameter int unsigned DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_data,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        tck,
   output logic        tms,
   output logic        tdi,
   input  logic        tdo
);

   hostState_t  state, stateNext;
   logic        loadCmd, loadSync;
   logic [1:0]  loadOp;
   logic [19:0] loadTms, loadShift;
   logic [15:0] loadData;

   logic [4:0]  edgesLeft;
   logic [19:0] tmsSr;      // TMS for the edges still to come, next at bit 0
   logic [19:0] shiftSr;    // shift-edge flags for the edges still to come
   logic        curShift;   // current edge is a shift edge
   logic [15:0] dataSr;     // outgoing bits, next at bit 15
   logic [15:0] capSr;      // captured TDO bits, shifted in at bit 0
   logic [15:0] rspData;
   logic        autoSync;   // running the post-reset SYNC: no response
   logic        run, riseTick, fallTick;

   assign run       = (state == StLow) || (state == StHigh);
   assign cmd_ready = (state == StReady);
   assign rsp_valid = (state == StDone);
   assign rsp_data  = rspData;

   jtag_host_tick #(
      .DIV(DIV)
   ) uTick (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .tckLevel (tck),
      .fall_tick(fallTick),
      .rise_tick(riseTick)
   );

   // Next-state logic.
   always_comb begin
      stateNext = state;
      loadCmd   = 1'b0;
      loadSync  = 1'b0;
      case (state)
         StResetSync: begin
            stateNext = StLow;
            loadSync  = 1'b1;
         end
         StReady: begin
            if (cmd_valid) begin
               stateNext = StLow;
               loadCmd   = 1'b1;
            end
         end
         StLow: begin
            if (riseTick) stateNext = StHigh;
         end
         StHigh: begin
            if (fallTick) begin
               if (edgesLeft != 5'd0) stateNext = StLow;
               else if (autoSync)     stateNext = StReady;
               else                   stateNext = StDone;
            end
         end
         StDone: stateNext = StReady;
         default: stateNext = StResetSync;
      endcase
   end

   // Values loaded when a sequence starts; the auto-sync always loads SYNC.
   always_comb begin
      loadOp = OP_SYNC;
      if (state == StReady) loadOp = normOp(cmd_op);
      loadTms   = tmsPattern(loadOp);
      loadShift = shiftPattern(loadOp);
      case (loadOp)
         OP_DSCAN: loadData = cmd_data;
         OP_ISCAN: loadData = {cmd_data[7:0], 8'h00};
         default:  loadData = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= StResetSync;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tck       <= 1'b0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
         edgesLeft <= '0;
         tmsSr     <= '0;
         shiftSr   <= '0;
         curShift  <= 1'b0;
         dataSr    <= '0;
         capSr     <= '0;
         rspData   <= '0;
         autoSync  <= 1'b0;
      end else if (loadCmd || loadSync) begin
         // This clk begins the low phase of edge 1.
         tms       <= loadTms[0];
         tmsSr     <= loadTms >> 1;
         curShift  <= loadShift[0];
         shiftSr   <= loadShift >> 1;
         tdi       <= loadShift[0] & loadData[15];
         dataSr    <= loadShift[0] ? (loadData << 1) : loadData;
         edgesLeft <= edgeCount(loadOp);
         capSr     <= '0;
         autoSync  <= loadSync;
      end else if (riseTick) begin
         tck       <= 1'b1;
         edgesLeft <= edgesLeft - 5'd1;
         if (curShift) capSr <= {capSr[14:0], tdo};
      end else if (fallTick) begin
         tck <= 1'b0;
         if (edgesLeft != 5'd0) begin
            tms      <= tmsSr[0];
            tmsSr    <= tmsSr >> 1;
            curShift <= shiftSr[0];
            shiftSr  <= shiftSr >> 1;
            tdi      <= shiftSr[0] & dataSr[15];
            if (shiftSr[0]) dataSr <= dataSr << 1;
         end else begin
            curShift <= 1'b0;
            if (!autoSync) rspData <= capSr;
         end
      end
   end

endmodule
